branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
//
// PURPOSE
// Parametrised, pipelined branch resolution unit for the EX stage of the 5-stage datapath.
// Compares two WIDTH-bit register operands under an 8-way condition code and registers the taken decision.
// Checks the decision against the fetch-stage prediction and raises a one-cycle mispredict/redirect.
// Keeps a saturating mispredict counter for performance debug.
// Supersedes the 2-bit-op, 16-bit combinational comparator. The legacy op codes 01/10/11 keep their meaning.
//
// PARAMETERS
// WIDTH     16  operand width in bits (>=2)
// LATENCY   1   1: outcome registered once; 2: operands also registered (input stage + outcome stage)
// CNT_W     8   width of the saturating mispredict counter
//
// PORTS
// clk           in   1        rising-edge clock
// rst_n         in   1        synchronous, active-low reset
// valid_in      in   1        branch_op/operands/pred_taken valid this cycle
// branch_op     in   3        condition code (see BEHAVIOUR)
// operand_a     in   WIDTH    rs value
// operand_b     in   WIDTH    comparison register (R15 in the ISA)
// pred_taken    in   1        prediction made at fetch for this branch
// stall         in   1        hold all pipeline registers
// flush_in      in   1        kill all in-flight entries
// cnt_clr       in   1        clear the mispredict counter
// valid_out     out  1        taken/mispredict valid
// taken         out  1        resolved branch outcome
// mispredict    out  1        valid_out & (taken != prediction)
// misp_count    out  CNT_W    saturating mispredict count
//
// BEHAVIOUR
// - Op codes:
//   - 000 NONE: never taken, and the entry is not a branch.
//   - 001 LT signed; 010 EQ; 011 GT signed; 100 NE; 101 GE signed; 110 LTU; 111 GEU.
// - Comparisons are true two's-complement or unsigned compares at WIDTH bits.
//   - There is no overflow error. Example: 0x8000 LT 0x7FFF is taken at WIDTH=16.
// - Reset (rst_n=0 at an edge) sets every register and output to 0, including misp_count.
//   - Reset has priority over every other input.
// - Pipeline:
//   - LATENCY=1: inputs sampled at edge N. valid_out/taken/mispredict are valid after edge N.
//   - LATENCY=2: operands are registered at edge N. The outcome is registered at edge N+1.
//   - One new branch per cycle. There is no backpressure output.
// - stall=1:
//   - All stage registers hold, and outputs hold their previous values.
//   - valid_in is ignored that cycle. Upstream must also stall.
// - flush_in=1:
//   - At the next edge all stage valid bits clear and valid_out=0.
//   - flush_in beats stall and valid_in.
//   - The entry present on the inputs is discarded.
// - Entries with valid_in=1 and op=NONE:
//   - valid_out=1, taken=0.
//   - mispredict = pred_taken. This lets the front end recover from a bad prediction on a non-branch.
// - Flag gating:
//   - mispredict and taken are 0 whenever valid_out=0.
//   - Each flag is asserted for exactly one cycle per entry, unless stall holds it.
// - misp_count:
//   - Increments at the edge where a mispredict=1 result is registered.
//   - A result held by stall is not recounted.
//   - Saturates at 2^CNT_W-1 with no wrap.
//   - When cnt_clr and an increment coincide, the clear wins and the count is 0.
//
// STRUCTURE
// - Package branch_pkg: localparam op codes (BR_NONE..BR_GEU) and the op width (3).
// - Sub-module branch_cmp_core: purely combinational (op, a, b) -> taken, parametrised by WIDTH.
// - Top: stage registers, the LATENCY generate branch, the flush/stall priority logic and the counter.
//
// TESTING
// 1. Reset: hold rst_n=0 for 2 edges with valid_in=1 -> valid_out=0, taken=0, mispredict=0, misp_count=0.
// 2. Signed vs unsigned (WIDTH=16):
//    - a=0x8000, b=0x0001, op=001 -> taken=1.
//    - The same operands with op=110 -> taken=0.
//    - a=b=0x1234, op=010 -> 1; op=100 -> 0.
// 3. Mispredict:
//    - op=011, a=5, b=3, pred_taken=0 -> taken=1, mispredict=1 for one cycle, misp_count 0->1.
//    - Result appears 1 cycle after sampling for LATENCY=1 and 2 cycles after for LATENCY=2.
// 4. Stall/flush:
//    - Stall for 3 cycles mid-pipe (LATENCY=2) -> outputs frozen and the counter increments once only.
//    - flush_in together with stall -> valid_out=0 next cycle.
// 5. Saturation (CNT_W=2):
//    - 5 consecutive mispredicts -> misp_count sticks at 3.
//    - cnt_clr on the same cycle as a mispredict -> count 0.
// 6. Back-to-back throughput:
//    - 8 consecutive branches, one per cycle, with random ops and operands.
//    - Scoreboard against a reference model: 8 results returned in order with no gaps.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Branch condition codes shared by the resolve unit, its compare core and its bus interface.
package branch_pkg;
  localparam int BR_OP_W = 3;

  localparam logic [BR_OP_W-1:0] BR_NONE = 3'b000;
  localparam logic [BR_OP_W-1:0] BR_LT   = 3'b001;
  localparam logic [BR_OP_W-1:0] BR_EQ   = 3'b010;
  localparam logic [BR_OP_W-1:0] BR_GT   = 3'b011;
  localparam logic [BR_OP_W-1:0] BR_NE   = 3'b100;
  localparam logic [BR_OP_W-1:0] BR_GE   = 3'b101;
  localparam logic [BR_OP_W-1:0] BR_LTU  = 3'b110;
  localparam logic [BR_OP_W-1:0] BR_GEU  = 3'b111;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// Issue/result bus of the branch resolve unit; master = EX control, slave = resolve unit.
interface branch_resolve_unit_if
  import branch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic               valid_in;
  logic [BR_OP_W-1:0] branch_op;
  logic [WIDTH-1:0]   operand_a;
  logic [WIDTH-1:0]   operand_b;
  logic               pred_taken;
  logic               stall;
  logic               flush_in;
  logic               cnt_clr;
  logic               valid_out;
  logic               taken;
  logic               mispredict;
  logic [CNT_W-1:0]   misp_count;

  modport master (
    output valid_in, branch_op, operand_a, operand_b, pred_taken, stall, flush_in, cnt_clr,
    input  valid_out, taken, mispredict, misp_count
  );

  modport slave (
    input  valid_in, branch_op, operand_a, operand_b, pred_taken, stall, flush_in, cnt_clr,
    output valid_out, taken, mispredict, misp_count
  );
endinterface

// File: rtl/branch_resolve_unit_cmp.sv
// Combinational condition evaluation: (op, a, b) -> taken. NONE and unknown codes are never taken.
module branch_cmp_core
  import branch_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [BR_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               taken_o
);
  logic eq, lt_s, lt_u;

  assign eq   = (a_i == b_i);
  assign lt_u = (a_i < b_i);
  assign lt_s = ($signed(a_i) < $signed(b_i));

  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      BR_LT:   taken_o = lt_s;
      BR_EQ:   taken_o = eq;
      BR_GT:   taken_o = !lt_s && !eq;
      BR_NE:   taken_o = !eq;
      BR_GE:   taken_o = !lt_s;
      BR_LTU:  taken_o = lt_u;
      BR_GEU:  taken_o = !lt_u;
      default: taken_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: optional operand stage, registered outcome/mispredict, saturating
// mispredict counter. Priority at each edge: reset > flush > stall > new entry.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_resolve_unit_if.slave br
);
  logic               src_vld, src_pred;
  logic [BR_OP_W-1:0] src_op;
  logic [WIDTH-1:0]   src_a, src_b;

  generate
    if (LATENCY == 2) begin : g_in_stage
      logic               s1_vld_q, s1_pred_q;
      logic [BR_OP_W-1:0] s1_op_q;
      logic [WIDTH-1:0]   s1_a_q, s1_b_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_vld_q  <= 1'b0;
          s1_pred_q <= 1'b0;
          s1_op_q   <= BR_NONE;
          s1_a_q    <= '0;
          s1_b_q    <= '0;
        end else if (br.flush_in) begin
          s1_vld_q  <= 1'b0;
        end else if (!br.stall) begin
          s1_vld_q  <= br.valid_in;
          s1_pred_q <= br.pred_taken;
          s1_op_q   <= br.branch_op;
          s1_a_q    <= br.operand_a;
          s1_b_q    <= br.operand_b;
        end
      end

      assign src_vld  = s1_vld_q;
      assign src_pred = s1_pred_q;
      assign src_op   = s1_op_q;
      assign src_a    = s1_a_q;
      assign src_b    = s1_b_q;
    end else begin : g_no_in_stage
      assign src_vld  = br.valid_in;
      assign src_pred = br.pred_taken;
      assign src_op   = br.branch_op;
      assign src_a    = br.operand_a;
      assign src_b    = br.operand_b;
    end
  endgenerate

  logic cmp_taken;

  branch_cmp_core #(.WIDTH(WIDTH)) u_cmp (
    .op_i    (src_op),
    .a_i     (src_a),
    .b_i     (src_b),
    .taken_o (cmp_taken)
  );

  logic             vld_q, taken_q, misp_q;
  logic             vld_d, taken_d, misp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             advance, res_misp;

  // A NONE entry never takes, so its mispredict reduces to the prediction itself.
  assign res_misp = src_vld && (cmp_taken != src_pred);
  assign advance  = !br.flush_in && !br.stall;

  always_comb begin
    vld_d   = vld_q;
    taken_d = taken_q;
    misp_d  = misp_q;
    cnt_d   = cnt_q;
    if (br.flush_in) begin
      vld_d   = 1'b0;
      taken_d = 1'b0;
      misp_d  = 1'b0;
    end else if (!br.stall) begin
      vld_d   = src_vld;
      taken_d = src_vld && cmp_taken;
      misp_d  = res_misp;
    end
    // Count only results actually registered this edge; held results were already counted.
    if (br.cnt_clr)
      cnt_d = '0;
    else if (advance && res_misp && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      taken_q <= 1'b0;
      misp_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      taken_q <= taken_d;
      misp_q  <= misp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign br.valid_out  = vld_q;
  assign br.taken      = taken_q;
  assign br.mispredict = misp_q;
  assign br.misp_count = cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Drives a LATENCY=1/CNT_W=8 and a LATENCY=2/CNT_W=2 instance with the same stimulus and
// checks both against an entry-level reference model every cycle.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.WIDTH(16), .CNT_W(8)) if1 ();
  branch_resolve_unit_if #(.WIDTH(16), .CNT_W(2)) if2 ();

  branch_resolve_unit #(.WIDTH(16), .LATENCY(1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .br(if1.slave));
  branch_resolve_unit #(.WIDTH(16), .LATENCY(2), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .br(if2.slave));

  typedef struct { bit v; bit t; bit m; } ent_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t m1_out, m2_s1, m2_out;
  int   cnt1, cnt2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int ua, ub, sa, sb;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    case (op)
      3'd1:    return sa < sb;
      3'd2:    return ua == ub;
      3'd3:    return sa > sb;
      3'd4:    return ua != ub;
      3'd5:    return sa >= sb;
      3'd6:    return ua < ub;
      3'd7:    return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input bit vin, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit pred, input bit stl, input bit fl, input bit clr);
    if1.valid_in = vin; if1.branch_op = op; if1.operand_a = a; if1.operand_b = b;
    if1.pred_taken = pred; if1.stall = stl; if1.flush_in = fl; if1.cnt_clr = clr;
    if2.valid_in = vin; if2.branch_op = op; if2.operand_a = a; if2.operand_b = b;
    if2.pred_taken = pred; if2.stall = stl; if2.flush_in = fl; if2.cnt_clr = clr;
  endtask

  // One clock: apply inputs, advance the model at the edge, compare just after it.
  task automatic step(input bit vin, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input bit pred, input bit stl, input bit fl, input bit clr);
    ent_t e;
    bit   inc1, inc2;
    drive(vin, op, a, b, pred, stl, fl, clr);
    @(posedge clk);
    e.v = vin;
    e.t = vin && ref_taken(op, a, b);
    e.m = vin && (ref_taken(op, a, b) != pred);
    if (!rst_n) begin
      m1_out = '{0, 0, 0}; m2_s1 = '{0, 0, 0}; m2_out = '{0, 0, 0};
      cnt1 = 0; cnt2 = 0;
    end else begin
      inc1 = !fl && !stl && e.v && e.m;
      inc2 = !fl && !stl && m2_s1.v && m2_s1.m;
      if (clr) cnt1 = 0; else if (inc1 && cnt1 < 255) cnt1++;
      if (clr) cnt2 = 0; else if (inc2 && cnt2 < 3) cnt2++;
      if (fl) begin
        m1_out = '{0, 0, 0}; m2_s1 = '{0, 0, 0}; m2_out = '{0, 0, 0};
      end else if (!stl) begin
        m1_out = e;
        m2_out = m2_s1;
        m2_s1  = e;
      end
    end
    #1;
    chk("d1.valid_out",  32'(if1.valid_out),  32'(m1_out.v));
    chk("d1.taken",      32'(if1.taken),      32'(m1_out.v && m1_out.t));
    chk("d1.mispredict", 32'(if1.mispredict), 32'(m1_out.v && m1_out.m));
    chk("d1.misp_count", 32'(if1.misp_count), 32'(cnt1));
    chk("d2.valid_out",  32'(if2.valid_out),  32'(m2_out.v));
    chk("d2.taken",      32'(if2.taken),      32'(m2_out.v && m2_out.t));
    chk("d2.mispredict", 32'(if2.mispredict), 32'(m2_out.v && m2_out.m));
    chk("d2.misp_count", 32'(if2.misp_count), 32'(cnt2));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, BR_NONE, 16'h0, 16'h0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    drive(0, BR_NONE, 16'h0, 16'h0, 0, 0, 0, 0);

    // Reset with valid_in asserted
    rst_n = 1'b0;
    step(1, BR_GT, 16'd5, 16'd3, 0, 0, 0, 0);
    step(1, BR_GT, 16'd5, 16'd3, 0, 0, 0, 0);
    chk("rst.d1.valid_out", 32'(if1.valid_out), 0);
    chk("rst.d1.mispredict", 32'(if1.mispredict), 0);
    chk("rst.d2.valid_out", 32'(if2.valid_out), 0);
    chk("rst.d2.misp_count", 32'(if2.misp_count), 0);
    rst_n = 1'b1;
    idle(2);

    // Signed vs unsigned, equality
    step(1, BR_LT, 16'h8000, 16'h0001, 1, 0, 0, 0);
    chk("lt_signed", 32'(if1.taken), 1);
    step(1, BR_LTU, 16'h8000, 16'h0001, 0, 0, 0, 0);
    chk("ltu", 32'(if1.taken), 0);
    chk("lat2_lt_signed", 32'(if2.taken), 1);
    step(1, BR_EQ, 16'h1234, 16'h1234, 1, 0, 0, 0);
    chk("eq", 32'(if1.taken), 1);
    step(1, BR_NE, 16'h1234, 16'h1234, 0, 0, 0, 0);
    chk("ne", 32'(if1.taken), 0);
    step(1, BR_LT, 16'h8000, 16'h7FFF, 1, 0, 0, 0);
    chk("lt_no_overflow", 32'(if1.taken), 1);

    // Mispredict: one-cycle flag, counter 0->1, one extra cycle for LATENCY=2
    step(1, BR_GT, 16'd5, 16'd3, 0, 0, 0, 0);
    chk("misp.d1", 32'(if1.mispredict), 1);
    chk("misp.d1.count", 32'(if1.misp_count), 1);
    chk("misp.d2.early", 32'(if2.mispredict), 0);
    idle(1);
    chk("misp.d1.one_cycle", 32'(if1.mispredict), 0);
    chk("misp.d2.lat2", 32'(if2.mispredict), 1);
    idle(1);

    // Stall 3 cycles mid-pipe; input during stall must be ignored
    step(1, BR_GT, 16'd5, 16'd3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, BR_LT, 16'd1, 16'd2, 0, 1, 0, 0);
      chk("stall.d1.hold", 32'(if1.mispredict), 1);
      chk("stall.d1.count", 32'(if1.misp_count), 2);
    end
    idle(3);

    // Flush together with stall
    step(1, BR_GT, 16'd5, 16'd3, 0, 0, 0, 0);
    step(1, BR_EQ, 16'd7, 16'd7, 0, 1, 1, 0);
    chk("flush.d1.valid_out", 32'(if1.valid_out), 0);
    chk("flush.d2.valid_out", 32'(if2.valid_out), 0);
    idle(2);

    // Saturation and clear-beats-increment
    step(0, BR_NONE, 16'h0, 16'h0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, BR_GT, 16'd5, 16'd3, 0, 0, 0, 0);
    idle(2);
    chk("sat.d2.count", 32'(if2.misp_count), 3);
    chk("sat.d1.count", 32'(if1.misp_count), 5);
    step(1, BR_NONE, 16'h0, 16'h0, 1, 0, 0, 1);
    chk("clr_wins.d1.count", 32'(if1.misp_count), 0);
    chk("none_misp.d1", 32'(if1.mispredict), 1);
    idle(2);

    // Back-to-back random branches
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      step(1, 3'($urandom), ra, rb, 1'($urandom), 0, 0, 0);
    end
    idle(3);

    // Random mix including stall, flush, clear and reset-free idle gaps
    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      step(($urandom_range(0, 9) < 8), 3'($urandom), ra, rb, 1'($urandom),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 4));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
